// File: rtl/load_writeback_unit_pkg.sv
// Shared constants for the load/writeback unit: register-file write patterns
// and the load-sequencing FSM state encoding.
package load_writeback_unit_pkg;

  localparam logic [2:0] REG_WRITE_BYTE_UNSIGNED = 3'd1;
  localparam logic [2:0] REG_WRITE_BYTE_SIGNED   = 3'd2;
  localparam logic [2:0] REG_WRITE_WORD          = 3'd4;

  typedef enum logic [1:0] {
    LWB_IDLE  = 2'd0,
    LWB_ISSUE = 2'd1,
    LWB_WAIT  = 2'd2
  } lwb_state_t;

  // Byte loads are shifted down; extension is left to the register file.
  function automatic logic is_byte_kind(input logic [2:0] kind);
    return (kind == REG_WRITE_BYTE_UNSIGNED) || (kind == REG_WRITE_BYTE_SIGNED);
  endfunction

endpackage

// File: rtl/load_byte_align.sv
// Moves the addressed byte of a load response down to bit 0; words pass
// through untouched.
module load_byte_align
  import load_writeback_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  kind,
  input  logic [31:0] data,
  output logic [31:0] aligned
);

  always_comb begin
    aligned = data;
    if (is_byte_kind(kind)) begin
      aligned = data >> {addr_lo, 3'b000};
    end
  end

endmodule

// File: rtl/load_writeback_unit.sv
// Load sequencer and register-file write-port arbiter. Load responses win the
// write port over ALU results; every rf_* output is registered.
//
// state      | meaning
// -----------+------------------------------------------------------------
// LWB_IDLE   | ready for a new load; ALU writes flow freely
// LWB_ISSUE  | memory read request presented, held until mem_rd_ready
// LWB_WAIT   | waiting for mem_rsp_valid, bounded by TIMEOUT_CYCLES
module load_writeback_unit
  import load_writeback_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  input  logic [2:0]  req_kind,
  output logic        mem_rd_valid,
  input  logic        mem_rd_ready,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        alu_wr_valid,
  output logic        alu_wr_ready,
  input  logic [4:0]  alu_wr_rd,
  input  logic [31:0] alu_wr_data,
  output logic        rf_wr_enable,
  output logic [4:0]  rf_wr_address,
  output logic [31:0] rf_wr_data,
  output logic [2:0]  rf_write_pattern,
  output logic        busy,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lwb_state_t  state;
  lwb_state_t  next_state;
  logic [31:0] lat_addr;
  logic [4:0]  lat_rd;
  logic [2:0]  lat_kind;
  logic [7:0]  wait_cnt;
  logic [31:0] aligned_data;

  logic accept;
  logic misaligned;
  logic load_rsp;
  logic timeout_hit;

  assign accept      = req_valid && (state == LWB_IDLE);
  assign misaligned  = (req_kind == REG_WRITE_WORD) && (req_addr[1:0] != 2'b00);
  assign load_rsp    = (state == LWB_WAIT) && mem_rsp_valid;
  // The response check comes first so a reply on the last allowed cycle still lands.
  assign timeout_hit = (state == LWB_WAIT) && !mem_rsp_valid && (wait_cnt == TIMEOUT_LAST);

  assign req_ready    = (state == LWB_IDLE);
  assign busy         = (state != LWB_IDLE);
  assign mem_rd_valid = (state == LWB_ISSUE);
  assign mem_rd_addr  = {lat_addr[31:2], 2'b00};
  assign alu_wr_ready = !load_rsp;

  load_byte_align u_align (
    .addr_lo (lat_addr[1:0]),
    .kind    (lat_kind),
    .data    (mem_rsp_data),
    .aligned (aligned_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LWB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LWB_IDLE: begin
        if (accept && !misaligned) next_state = LWB_ISSUE;
      end
      LWB_ISSUE: begin
        if (mem_rd_ready) next_state = LWB_WAIT;
      end
      LWB_WAIT: begin
        if (mem_rsp_valid || timeout_hit) next_state = LWB_IDLE;
      end
      default: next_state = LWB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr <= '0;
      lat_rd   <= '0;
      lat_kind <= '0;
    end else if (accept) begin
      lat_addr <= req_addr;
      lat_rd   <= req_rd;
      lat_kind <= req_kind;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == LWB_ISSUE) begin
      wait_cnt <= '0;
    end else if ((state == LWB_WAIT) && !mem_rsp_valid && !timeout_hit) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      misalign_err <= accept && misaligned;
      timeout_err  <= timeout_hit;
    end
  end

  // Data/address/pattern hold their last value whenever no write is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr_enable     <= 1'b0;
      rf_wr_address    <= '0;
      rf_wr_data       <= '0;
      rf_write_pattern <= '0;
    end else begin
      rf_wr_enable <= 1'b0;
      if (load_rsp) begin
        rf_wr_enable     <= (lat_rd != 5'd0);
        rf_wr_address    <= lat_rd;
        rf_wr_data       <= aligned_data;
        rf_write_pattern <= lat_kind;
      end else if (alu_wr_valid) begin
        rf_wr_enable     <= (alu_wr_rd != 5'd0);
        rf_wr_address    <= alu_wr_rd;
        rf_wr_data       <= alu_wr_data;
        rf_write_pattern <= REG_WRITE_WORD;
      end
    end
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit with a short timeout so the abandon
// path is reachable in a handful of cycles.
module tb_load_writeback_unit;
  import load_writeback_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic [2:0]  req_kind;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        alu_wr_valid;
  logic        alu_wr_ready;
  logic [4:0]  alu_wr_rd;
  logic [31:0] alu_wr_data;
  logic        rf_wr_enable;
  logic [4:0]  rf_wr_address;
  logic [31:0] rf_wr_data;
  logic [2:0]  rf_write_pattern;
  logic        busy;
  logic        misalign_err;
  logic        timeout_err;

  int total;
  int bad;

  load_writeback_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_rd           (req_rd),
    .req_kind         (req_kind),
    .mem_rd_valid     (mem_rd_valid),
    .mem_rd_ready     (mem_rd_ready),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .alu_wr_valid     (alu_wr_valid),
    .alu_wr_ready     (alu_wr_ready),
    .alu_wr_rd        (alu_wr_rd),
    .alu_wr_data      (alu_wr_data),
    .rf_wr_enable     (rf_wr_enable),
    .rf_wr_address    (rf_wr_address),
    .rf_wr_data       (rf_wr_data),
    .rf_write_pattern (rf_write_pattern),
    .busy             (busy),
    .misalign_err     (misalign_err),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [4:0] rd, input logic [2:0] kind);
    req_valid = 1'b1;
    req_addr  = addr;
    req_rd    = rd;
    req_kind  = kind;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (alu_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_alu_ready got=%b exp=1", alu_wr_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (mem_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_rd_valid got=%b exp=0", mem_rd_valid); end
    total++; if (mem_rd_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_rd_addr got=%h exp=0", mem_rd_addr); end
    total++; if (rf_wr_enable !== 1'b0) begin bad++; $display("FAIL reset_rf_en got=%b exp=0", rf_wr_enable); end
    total++; if (rf_wr_data !== 32'h0) begin bad++; $display("FAIL reset_rf_data got=%h exp=0", rf_wr_data); end
    total++; if ({misalign_err, timeout_err} !== 2'b00) begin bad++; $display("FAIL reset_errs got=%b exp=00", {misalign_err, timeout_err}); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lbu();
    drive_req(32'h0000_0103, 5'd5, REG_WRITE_BYTE_UNSIGNED);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lbu_req_ready got=%b exp=1", req_ready); end
    step();
    req_valid = 1'b0;
    total++; if (mem_rd_valid !== 1'b1) begin bad++; $display("FAIL lbu_mem_rd_valid got=%b exp=1", mem_rd_valid); end
    total++; if (mem_rd_addr !== 32'h0000_0100) begin bad++; $display("FAIL lbu_mem_rd_addr got=%h exp=00000100", mem_rd_addr); end
    total++; if ({busy, req_ready} !== 2'b10) begin bad++; $display("FAIL lbu_busy_ready got=%b exp=10", {busy, req_ready}); end
    mem_rd_ready = 1'b1;
    step();
    mem_rd_ready = 1'b0;
    total++; if (mem_rd_valid !== 1'b0) begin bad++; $display("FAIL lbu_wait_mem_rd_valid got=%b exp=0", mem_rd_valid); end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hAABB_CCDD;
    #1;
    total++; if (alu_wr_ready !== 1'b0) begin bad++; $display("FAIL lbu_alu_ready_rsp got=%b exp=0", alu_wr_ready); end
    step();
    mem_rsp_valid = 1'b0;
    total++; if (rf_wr_enable !== 1'b1) begin bad++; $display("FAIL lbu_rf_en got=%b exp=1", rf_wr_enable); end
    total++; if (rf_wr_address !== 5'd5) begin bad++; $display("FAIL lbu_rf_addr got=%0d exp=5", rf_wr_address); end
    total++; if (rf_wr_data !== 32'h0000_00AA) begin bad++; $display("FAIL lbu_rf_data got=%h exp=000000aa", rf_wr_data); end
    total++; if (rf_write_pattern !== REG_WRITE_BYTE_UNSIGNED) begin bad++; $display("FAIL lbu_rf_pattern got=%0d exp=%0d", rf_write_pattern, REG_WRITE_BYTE_UNSIGNED); end
    total++; if ({busy, req_ready} !== 2'b01) begin bad++; $display("FAIL lbu_back_to_idle got=%b exp=01", {busy, req_ready}); end
    step();
    total++; if (rf_wr_enable !== 1'b0) begin bad++; $display("FAIL lbu_rf_en_pulse got=%b exp=0", rf_wr_enable); end
    total++; if (rf_wr_data !== 32'h0000_00AA) begin bad++; $display("FAIL lbu_rf_data_hold got=%h exp=000000aa", rf_wr_data); end
  endtask

  task automatic test_misalign();
    drive_req(32'h0000_0102, 5'd3, REG_WRITE_WORD);
    step();
    req_valid = 1'b0;
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", misalign_err); end
    total++; if ({req_ready, busy, mem_rd_valid, rf_wr_enable} !== 4'b1000) begin bad++; $display("FAIL mis_state got=%b exp=1000", {req_ready, busy, mem_rd_valid, rf_wr_enable}); end
    step();
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_err_pulse got=%b exp=0", misalign_err); end
    total++; if ({mem_rd_valid, rf_wr_enable, req_ready} !== 3'b001) begin bad++; $display("FAIL mis_after got=%b exp=001", {mem_rd_valid, rf_wr_enable, req_ready}); end
  endtask

  task automatic test_alu_collision();
    drive_req(32'h0000_0200, 5'd0, REG_WRITE_BYTE_SIGNED);
    mem_rd_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    mem_rd_ready  = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0080;
    alu_wr_valid  = 1'b1;
    alu_wr_rd     = 5'd7;
    alu_wr_data   = 32'h0000_1234;
    #1;
    total++; if (alu_wr_ready !== 1'b0) begin bad++; $display("FAIL col_alu_blocked got=%b exp=0", alu_wr_ready); end
    step();
    mem_rsp_valid = 1'b0;
    total++; if (rf_wr_enable !== 1'b0) begin bad++; $display("FAIL col_rd0_en got=%b exp=0", rf_wr_enable); end
    total++; if (rf_wr_data !== 32'h0000_0080) begin bad++; $display("FAIL col_rd0_data got=%h exp=00000080", rf_wr_data); end
    total++; if (rf_write_pattern !== REG_WRITE_BYTE_SIGNED) begin bad++; $display("FAIL col_rd0_pattern got=%0d exp=%0d", rf_write_pattern, REG_WRITE_BYTE_SIGNED); end
    total++; if (alu_wr_ready !== 1'b1) begin bad++; $display("FAIL col_alu_ready_after got=%b exp=1", alu_wr_ready); end
    step();
    alu_wr_valid = 1'b0;
    total++; if ({rf_wr_enable, rf_wr_address} !== {1'b1, 5'd7}) begin bad++; $display("FAIL col_alu_write got=%b/%0d exp=1/7", rf_wr_enable, rf_wr_address); end
    total++; if (rf_wr_data !== 32'h0000_1234) begin bad++; $display("FAIL col_alu_data got=%h exp=00001234", rf_wr_data); end
    total++; if (rf_write_pattern !== REG_WRITE_WORD) begin bad++; $display("FAIL col_alu_pattern got=%0d exp=%0d", rf_write_pattern, REG_WRITE_WORD); end
    step();
  endtask

  task automatic test_stall_lw();
    drive_req(32'h0000_0300, 5'd9, REG_WRITE_WORD);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if ({mem_rd_valid, mem_rd_addr} !== {1'b1, 32'h0000_0300}) begin bad++; $display("FAIL stall_hold_%0d got=%b/%h exp=1/00000300", i, mem_rd_valid, mem_rd_addr); end
      if (i == 1) begin
        total++; if ({rf_wr_enable, rf_wr_address, rf_wr_data} !== {1'b1, 5'd2, 32'h55}) begin bad++; $display("FAIL stall_alu_write got=%b/%0d/%h exp=1/2/00000055", rf_wr_enable, rf_wr_address, rf_wr_data); end
      end
      if (i == 0) begin
        alu_wr_valid = 1'b1;
        alu_wr_rd    = 5'd2;
        alu_wr_data  = 32'h0000_0055;
      end
      step();
      alu_wr_valid = 1'b0;
    end
    mem_rd_ready = 1'b1;
    step();
    mem_rd_ready = 1'b0;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    step();
    mem_rsp_valid = 1'b0;
    total++; if ({rf_wr_enable, rf_wr_address} !== {1'b1, 5'd9}) begin bad++; $display("FAIL lw_write got=%b/%0d exp=1/9", rf_wr_enable, rf_wr_address); end
    total++; if (rf_wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", rf_wr_data); end
    total++; if (rf_write_pattern !== REG_WRITE_WORD) begin bad++; $display("FAIL lw_pattern got=%0d exp=%0d", rf_write_pattern, REG_WRITE_WORD); end
    step();
  endtask

  task automatic test_timeout();
    drive_req(32'h0000_0400, 5'd4, REG_WRITE_BYTE_UNSIGNED);
    mem_rd_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    mem_rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({busy, timeout_err} !== 2'b10) begin bad++; $display("FAIL to_waiting_%0d got=%b exp=10", i, {busy, timeout_err}); end
    end
    step();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", timeout_err); end
    total++; if ({rf_wr_enable, busy, req_ready} !== 3'b001) begin bad++; $display("FAIL to_idle got=%b exp=001", {rf_wr_enable, busy, req_ready}); end
    step();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=%b exp=0", timeout_err); end

    drive_req(32'h0000_0401, 5'd4, REG_WRITE_BYTE_UNSIGNED);
    mem_rd_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    mem_rd_ready = 1'b0;
    step();
    step();
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1122_3344;
    step();
    mem_rsp_valid = 1'b0;
    total++; if ({rf_wr_enable, timeout_err} !== 2'b10) begin bad++; $display("FAIL to_last_rsp got=%b exp=10", {rf_wr_enable, timeout_err}); end
    total++; if (rf_wr_data !== 32'h0011_2233) begin bad++; $display("FAIL to_last_data got=%h exp=00112233", rf_wr_data); end
    step();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_last_no_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    drive_req(32'h0000_0500, 5'd6, REG_WRITE_WORD);
    mem_rd_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    mem_rd_ready = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_in_wait got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, req_ready, alu_wr_ready, mem_rd_valid} !== 4'b0110) begin bad++; $display("FAIL rmid_async got=%b exp=0110", {busy, req_ready, alu_wr_ready, mem_rd_valid}); end
    step();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFE_F00D;
    step();
    mem_rsp_valid = 1'b0;
    total++; if ({rf_wr_enable, timeout_err, misalign_err, busy} !== 4'b0000) begin bad++; $display("FAIL rmid_late_rsp got=%b exp=0000", {rf_wr_enable, timeout_err, misalign_err, busy}); end
    total++; if ({rf_wr_data, mem_rd_addr} !== 64'h0) begin bad++; $display("FAIL rmid_reset_vals got=%h/%h exp=0/0", rf_wr_data, mem_rd_addr); end
    step();
    total++; if ({rf_wr_enable, timeout_err} !== 2'b00) begin bad++; $display("FAIL rmid_quiet got=%b exp=00", {rf_wr_enable, timeout_err}); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_rd        = '0;
    req_kind      = '0;
    mem_rd_ready  = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    alu_wr_valid  = 1'b0;
    alu_wr_rd     = '0;
    alu_wr_data   = '0;
    test_reset();
    test_lbu();
    test_misalign();
    test_alu_collision();
    test_stall_lw();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
